// File: rtl/audio_tone_pkg.sv
// Shared types and Q1.15 constants for the audio tone generator.
package audio_tone_pkg;

   // Control FSM states; IDLE must stay at encoding 0 so a reset state reads as zero.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Waveform selector, same encoding as the cfg_waveform register field.
   typedef enum logic [1:0] {
      WAVE_SQUARE   = 2'd0,
      WAVE_SAW      = 2'd1,
      WAVE_TRIANGLE = 2'd2,
      WAVE_SILENCE  = 2'd3
   } wave_t;

   // Q1.15 full-scale negative and positive waveform values.
   localparam logic [15:0] Q15_NEG_ONE = 16'h8000;
   localparam logic [15:0] Q15_POS_MAX = 16'h7FFF;

   // Largest legal gain (1.0 in unsigned Q1.15).
   localparam logic [15:0] Q15_UNITY_GAIN = 16'h8000;

   // Gains above unity are clamped so the multiply can never overflow 16 bits.
   function automatic logic [15:0] clamp_gain(input logic [15:0] gain);
      return (gain > Q15_UNITY_GAIN) ? Q15_UNITY_GAIN : gain;
   endfunction

endpackage

// File: rtl/audio_tone_gen_if.sv
// AXI-Stream sample output of the audio tone generator.
//
// Handshake: a beat transfers on a rising clock edge where tvalid && tready
// are both high. Once tvalid is raised, tvalid and tdata stay unchanged
// until that transfer edge; tready may change freely at any time.
interface audio_tone_gen_if #(
   parameter int SAMPLE_W = 16
);
   logic [SAMPLE_W-1:0] tdata;
   logic                tvalid;
   logic                tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/audio_wave_shaper.sv
// Maps the top 16 phase bits to a signed Q1.15 waveform value, registered
// once (pipeline stage 1). A valid bit travels alongside the value.
module audio_wave_shaper
   import audio_tone_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [15:0]        p,
   input  wave_t              wave,
   output logic signed [15:0] w,
   output logic               out_valid
);

   logic [14:0] fold;
   logic [15:0] w_next;

   // Waveform lookup: square, saw (offset-binary to signed), folded triangle, silence.
   always_comb begin
      fold   = p[15] ? ~p[14:0] : p[14:0];
      w_next = '0;
      case (wave)
         WAVE_SQUARE:   w_next = p[15] ? Q15_NEG_ONE : Q15_POS_MAX;
         WAVE_SAW:      w_next = p ^ 16'h8000;
         WAVE_TRIANGLE: w_next = {fold, fold[14]} ^ 16'h8000;
         WAVE_SILENCE:  w_next = '0;
         default:       w_next = '0;
      endcase
   end

   // Stage-1 register: capture the waveform value for every sample tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         w         <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            w <= w_next;
         end
      end
   end

endmodule

// File: rtl/audio_tone_gen.sv
// Audio tone generator: phase accumulator + waveform shaper + gain stage,
// streaming signed samples out over AXI-Stream. Samples appear two clocks
// after their sample_tick; a sample finishing while the output register is
// still held is dropped (overrun).
// Optional feature macro: AUDIO_TONE_GEN_OVERRUN_CNT_EN adds a saturating
// 16-bit overrun_cnt output counting dropped samples.
module audio_tone_gen
   import audio_tone_pkg::*;
#(
   parameter int PHASE_W  = 32,
   parameter int SAMPLE_W = 16
) (
   input  logic               ACLK,
   input  logic               ARESET,
   input  logic               cfg_enable,
   input  logic [PHASE_W-1:0] cfg_phase_inc,
   input  logic [15:0]        cfg_amplitude,
   input  logic [1:0]         cfg_waveform,
   input  logic               sample_tick,
   audio_tone_gen_if.master   m_axis,
   output logic               busy,
   output state_t             dbg_state
`ifdef AUDIO_TONE_GEN_OVERRUN_CNT_EN
   ,
   output logic [15:0]        overrun_cnt
`endif
);

   state_t               state;
   logic [PHASE_W-1:0]   phase;
   logic [PHASE_W-1:0]   inc_lat;
   logic [15:0]          amp_lat;
   wave_t                wave_lat;
   logic [PHASE_W:0]     phase_sum;
   logic                 wrap;
   logic                 step;
   logic [15:0]          amp_s1;
   logic signed [15:0]   w_s1;
   logic                 s1_valid;
   logic signed [32:0]   product;

   assign dbg_state = state;

   // Phase add with carry; the carry marks the end of a waveform period.
   always_comb begin
      phase_sum = {1'b0, phase} + {1'b0, inc_lat};
      wrap      = phase_sum[PHASE_W];
      step      = sample_tick && (state != IDLE);
      product   = 33'(w_s1) * 33'($signed({1'b0, amp_s1}));
   end

   // Control FSM and phase accumulator; config is re-latched only at a phase wrap.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state    <= IDLE;
         busy     <= 1'b0;
         phase    <= '0;
         inc_lat  <= '0;
         amp_lat  <= '0;
         wave_lat <= WAVE_SQUARE;
      end else begin
         case (state)
            IDLE: begin
               if (sample_tick && cfg_enable) begin
                  state    <= RUN;
                  busy     <= 1'b1;
                  phase    <= '0;
                  inc_lat  <= cfg_phase_inc;
                  amp_lat  <= clamp_gain(cfg_amplitude);
                  wave_lat <= wave_t'(cfg_waveform);
               end
            end
            RUN, DRAIN: begin
               if (sample_tick) begin
                  phase <= phase_sum[PHASE_W-1:0];
                  if (wrap) begin
                     inc_lat  <= cfg_phase_inc;
                     amp_lat  <= clamp_gain(cfg_amplitude);
                     wave_lat <= wave_t'(cfg_waveform);
                  end
                  if (state == RUN) begin
                     if (!cfg_enable) begin
                        state <= DRAIN;
                     end
                  end else if (cfg_enable) begin
                     state <= RUN;
                  end else if (wrap) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   audio_wave_shaper u_shaper (
      .clk       (ACLK),
      .rst       (ARESET),
      .in_valid  (step),
      .p         (phase[PHASE_W-1 -: 16]),
      .wave      (wave_lat),
      .w         (w_s1),
      .out_valid (s1_valid)
   );

   // Gain travels with its sample through stage 1 so a re-latch cannot skew it.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         amp_s1 <= '0;
      end else if (step) begin
         amp_s1 <= amp_lat;
      end
   end

   // Stage 2 / output register: load when empty or being accepted, else drop.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         m_axis.tvalid <= 1'b0;
         m_axis.tdata  <= '0;
      end else begin
         if (m_axis.tvalid && m_axis.tready) begin
            m_axis.tvalid <= 1'b0;
         end
         if (s1_valid && (!m_axis.tvalid || m_axis.tready)) begin
            m_axis.tvalid <= 1'b1;
            m_axis.tdata  <= SAMPLE_W'($signed(16'(product >>> 15)));
         end
      end
   end

`ifdef AUDIO_TONE_GEN_OVERRUN_CNT_EN
   // Count samples dropped at the held output register, saturating at all-ones.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         overrun_cnt <= '0;
      end else if (s1_valid && m_axis.tvalid && !m_axis.tready && (overrun_cnt != 16'hFFFF)) begin
         overrun_cnt <= overrun_cnt + 16'd1;
      end
   end
`else
   // Overrun drops are silent: the held sample is kept and nothing is counted.
`endif

endmodule

// File: tb/tb_audio_tone_gen.sv
// Self-checking bench for audio_tone_gen: directed scenarios plus a
// randomized run against a behavioural tone model.
module tb_audio_tone_gen;
   import audio_tone_pkg::*;

   localparam int PHASE_W  = 32;
   localparam int SAMPLE_W = 16;

   logic               ACLK = 1'b0;
   logic               ARESET;
   logic               cfg_enable;
   logic [PHASE_W-1:0] cfg_phase_inc;
   logic [15:0]        cfg_amplitude;
   logic [1:0]         cfg_waveform;
   logic               sample_tick;
   logic               busy;
   state_t             dbg_state;
`ifdef AUDIO_TONE_GEN_OVERRUN_CNT_EN
   logic [15:0]        overrun_cnt;
`endif

   audio_tone_gen_if #(.SAMPLE_W(SAMPLE_W)) m_axis ();

   audio_tone_gen #(.PHASE_W(PHASE_W), .SAMPLE_W(SAMPLE_W)) dut (
      .ACLK          (ACLK),
      .ARESET        (ARESET),
      .cfg_enable    (cfg_enable),
      .cfg_phase_inc (cfg_phase_inc),
      .cfg_amplitude (cfg_amplitude),
      .cfg_waveform  (cfg_waveform),
      .sample_tick   (sample_tick),
      .m_axis        (m_axis),
      .busy          (busy),
      .dbg_state     (dbg_state)
`ifdef AUDIO_TONE_GEN_OVERRUN_CNT_EN
      ,
      .overrun_cnt   (overrun_cnt)
`endif
   );

   // ---------------- clock / reset ----------------
   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always #5 ACLK = ~ACLK;
   always @(posedge ACLK) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model / scoreboard ----------------
   logic [15:0]     exp_q[$];
   int              due_q[$];
   bit              m_active;
   bit              m_drain;
   longint unsigned m_phase;
   longint unsigned m_inc;
   int              m_amp;
   int              m_wave;

   function automatic int wave_value(int wsel, int p16);
      int t;
      case (wsel)
         0: return (p16 >= 32768) ? -32768 : 32767;
         1: return p16 - 32768;
         2: begin
            t = (p16 < 32768) ? p16 : 65535 - p16;
            return 2 * t + ((t >= 16384) ? 1 : 0) - 32768;
         end
         default: return 0;
      endcase
   endfunction

   function automatic int scaled(int w, int amp);
      longint prod;
      prod = longint'(w) * longint'(amp);
      return int'(prod >>> 15);
   endfunction

   function automatic int gain_of(logic [15:0] a);
      return (a > 16'h8000) ? 32768 : int'(a);
   endfunction

   // Apply one sample tick to the model, using the config currently driven.
   task automatic model_tick();
      longint unsigned sum;
      bit wrap;
      if (!m_active) begin
         if (cfg_enable) begin
            m_active = 1'b1;
            m_drain  = 1'b0;
            m_phase  = 0;
            m_inc    = longint'(cfg_phase_inc);
            m_amp    = gain_of(cfg_amplitude);
            m_wave   = int'(cfg_waveform);
         end
      end else begin
         exp_q.push_back(16'(scaled(wave_value(m_wave, int'(m_phase >> 16)), m_amp)));
         due_q.push_back(cyc + 2);
         sum     = m_phase + m_inc;
         wrap    = (sum > 64'hFFFF_FFFF);
         m_phase = sum & 64'hFFFF_FFFF;
         if (wrap) begin
            m_inc  = longint'(cfg_phase_inc);
            m_amp  = gain_of(cfg_amplitude);
            m_wave = int'(cfg_waveform);
         end
         if (!m_drain) begin
            if (!cfg_enable) m_drain = 1'b1;
         end else if (cfg_enable) begin
            m_drain = 1'b0;
         end else if (wrap) begin
            m_active = 1'b0;
         end
      end
   endtask

   // ---------------- drivers ----------------
   task automatic do_reset();
      ARESET        = 1'b1;
      sample_tick   = 1'b0;
      cfg_enable    = 1'b0;
      cfg_phase_inc = '0;
      cfg_amplitude = '0;
      cfg_waveform  = '0;
      m_axis.tready = 1'b1;
      repeat (2) @(posedge ACLK);
      #1;
      ARESET = 1'b0;
   endtask

   // One clock with the given tick level; returns 1 time unit after the edge.
   task automatic cycle(input bit tick);
      sample_tick = tick;
      @(posedge ACLK);
      #1;
      sample_tick = 1'b0;
   endtask

   task automatic start_tone(input logic [31:0] inc, input logic [15:0] amp, input logic [1:0] wave);
      cfg_enable    = 1'b1;
      cfg_phase_inc = inc;
      cfg_amplitude = amp;
      cfg_waveform  = wave;
      cycle(1'b1);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      ARESET        = 1'b1;
      sample_tick   = 1'b1;
      cfg_enable    = 1'b1;
      cfg_phase_inc = 32'h4000_0000;
      cfg_amplitude = 16'h8000;
      cfg_waveform  = 2'd1;
      m_axis.tready = 1'b0;
      repeat (3) @(posedge ACLK);
      #1;
      checks++; if (m_axis.tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid: got %0b want 0", m_axis.tvalid); end
      checks++; if (m_axis.tdata !== 16'h0000) begin failures++; $display("FAIL reset_tdata: got %h want 0000", m_axis.tdata); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b want 0", busy); end
      checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
`ifdef AUDIO_TONE_GEN_OVERRUN_CNT_EN
      checks++; if (overrun_cnt !== 16'd0) begin failures++; $display("FAIL reset_overrun_cnt: got %0d want 0", overrun_cnt); end
`endif
      ARESET      = 1'b0;
      sample_tick = 1'b0;
      cycle(1'b0);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_priority_busy: got %0b want 0", busy); end
   endtask

   task automatic test_square();
      logic [15:0] sq_exp[4];
      sq_exp = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000};
      do_reset();
      start_tone(32'h4000_0000, 16'h8000, 2'd0);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL square_busy: got %0b want 1", busy); end
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1);
         checks++; if (m_axis.tvalid !== 1'b0) begin failures++; $display("FAIL square_early_%0d: tvalid got %0b want 0", i, m_axis.tvalid); end
         cycle(1'b0);
         checks++; if (m_axis.tvalid !== 1'b1) begin failures++; $display("FAIL square_valid_%0d: tvalid got %0b want 1", i, m_axis.tvalid); end
         checks++; if (m_axis.tdata !== sq_exp[i % 4]) begin failures++; $display("FAIL square_data_%0d: got %h want %h", i, m_axis.tdata, sq_exp[i % 4]); end
         cycle(1'b0);
      end
   endtask

   task automatic test_saw_back_to_back();
      logic [15:0] e;
      do_reset();
      start_tone(32'h1000_0000, 16'h4000, 2'd1);
      for (int c = 0; c < 18; c++) begin
         cycle(c < 16);
         if (c >= 1 && c <= 16) begin
            e = 16'((c - 1) * 2048 - 16384);
            checks++; if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== e) begin
               failures++; $display("FAIL saw_b2b_%0d: got valid=%0b data=%h want valid=1 data=%h", c - 1, m_axis.tvalid, m_axis.tdata, e);
            end
         end else begin
            checks++; if (m_axis.tvalid !== 1'b0) begin failures++; $display("FAIL saw_b2b_idle_%0d: tvalid got %0b want 0", c, m_axis.tvalid); end
         end
      end
   endtask

   task automatic test_overrun();
      do_reset();
      m_axis.tready = 1'b0;
      start_tone(32'h4000_0000, 16'h8000, 2'd1);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1);
         cycle(1'b0);
         checks++; if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== 16'h8000) begin
            failures++; $display("FAIL overrun_hold_%0d: got valid=%0b data=%h want valid=1 data=8000", i, m_axis.tvalid, m_axis.tdata);
         end
         cycle(1'b0);
      end
`ifdef AUDIO_TONE_GEN_OVERRUN_CNT_EN
      checks++; if (overrun_cnt !== 16'd2) begin failures++; $display("FAIL overrun_cnt: got %0d want 2", overrun_cnt); end
`endif
      m_axis.tready = 1'b1;
      cycle(1'b0);
      checks++; if (m_axis.tvalid !== 1'b0) begin failures++; $display("FAIL overrun_accept: tvalid got %0b want 0", m_axis.tvalid); end
      cycle(1'b1);
      cycle(1'b0);
      checks++; if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== 16'h4000) begin
         failures++; $display("FAIL overrun_next: got valid=%0b data=%h want valid=1 data=4000", m_axis.tvalid, m_axis.tdata);
      end
   endtask

   task automatic test_amp_change();
      logic [15:0] amp_exp[9];
      amp_exp = '{16'h8000, 16'hC000, 16'h0000, 16'h4000, 16'hC000, 16'hE000, 16'h0000, 16'h2000, 16'h8000};
      do_reset();
      start_tone(32'h4000_0000, 16'h8000, 2'd1);
      for (int i = 0; i < 9; i++) begin
         if (i == 1) cfg_amplitude = 16'h4000;
         if (i == 5) cfg_amplitude = 16'hFFFF;
         cycle(1'b1);
         cycle(1'b0);
         checks++; if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== amp_exp[i]) begin
            failures++; $display("FAIL amp_change_%0d: got valid=%0b data=%h want valid=1 data=%h", i, m_axis.tvalid, m_axis.tdata, amp_exp[i]);
         end
         cycle(1'b0);
      end
   endtask

   task automatic test_drain();
      logic [15:0] got[$];
      do_reset();
      start_tone(32'h4000_0000, 16'h8000, 2'd1);
      repeat (2) begin
         cycle(1'b1);
         cycle(1'b0);
         cycle(1'b0);
      end
      cfg_enable = 1'b0;
      for (int t = 0; t < 4; t++) begin
         cycle(1'b1);
         if (m_axis.tvalid === 1'b1) got.push_back(m_axis.tdata);
         if (t == 0) begin
            checks++; if (busy !== 1'b1 || dbg_state !== DRAIN) begin
               failures++; $display("FAIL drain_state: got busy=%0b state=%0d want busy=1 state=%0d", busy, dbg_state, DRAIN);
            end
         end
         repeat (2) begin
            cycle(1'b0);
            if (m_axis.tvalid === 1'b1) got.push_back(m_axis.tdata);
         end
      end
      checks++; if (got.size() != 2) begin failures++; $display("FAIL drain_count: got %0d samples want 2", got.size()); end
      else begin
         checks++; if (got[0] !== 16'h0000 || got[1] !== 16'h4000) begin
            failures++; $display("FAIL drain_values: got %h %h want 0000 4000", got[0], got[1]);
         end
      end
      checks++; if (busy !== 1'b0 || dbg_state !== IDLE) begin
         failures++; $display("FAIL drain_idle: got busy=%0b state=%0d want busy=0 state=%0d", busy, dbg_state, IDLE);
      end
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      do_reset();
      start_tone(32'h4000_0000, 16'h8000, 2'd0);
      cycle(1'b1);
      ARESET = 1'b1;
      cycle(1'b0);
      ARESET = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (m_axis.tvalid !== 1'b0) seen++;
         cycle(1'b0);
      end
      checks++; if (seen != 0) begin failures++; $display("FAIL reset_mid_tvalid: tvalid seen %0d cycles want 0", seen); end
      checks++; if (m_axis.tdata !== 16'h0000) begin failures++; $display("FAIL reset_mid_tdata: got %h want 0000", m_axis.tdata); end
      checks++; if (busy !== 1'b0 || dbg_state !== IDLE) begin
         failures++; $display("FAIL reset_mid_state: got busy=%0b state=%0d want busy=0 state=%0d", busy, dbg_state, IDLE);
      end
`ifdef AUDIO_TONE_GEN_OVERRUN_CNT_EN
      checks++; if (overrun_cnt !== 16'd0) begin failures++; $display("FAIL reset_mid_overrun_cnt: got %0d want 0", overrun_cnt); end
`endif
   endtask

   task automatic test_random_model();
      int          gap = 0;
      bit          tk;
      logic [15:0] e;
      int          d;
      do_reset();
      exp_q.delete();
      due_q.delete();
      m_active   = 1'b0;
      m_drain    = 1'b0;
      cfg_enable = 1'b1;
      for (int c = 0; c < 1203; c++) begin
         tk = (c < 1200) && (gap == 0);
         if (tk) begin
            if ($urandom_range(0, 5) == 0) cfg_enable = ~cfg_enable;
            cfg_phase_inc = 32'h1000_0000 | ($urandom & 32'h0FFF_FFFF);
            if ($urandom_range(0, 3) == 0) cfg_phase_inc = $urandom | 32'h1000_0000;
            cfg_amplitude = 16'($urandom_range(0, 65535));
            cfg_waveform  = 2'($urandom_range(0, 3));
            model_tick();
            gap = $urandom_range(0, 3);
         end else if (gap > 0) begin
            gap--;
         end
         cycle(tk);
         if (m_axis.tvalid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++; $display("FAIL random_unexpected: cycle %0d data=%h want no sample", cyc, m_axis.tdata);
            end else begin
               e = exp_q.pop_front();
               d = due_q.pop_front();
               if (m_axis.tdata !== e || d != cyc) begin
                  failures++; $display("FAIL random_sample: cycle %0d data=%h want data=%h at cycle %0d", cyc, m_axis.tdata, e, d);
               end
            end
         end
         checks++; if (busy !== m_active) begin failures++; $display("FAIL random_busy: cycle %0d got %0b want %0b", cyc, busy, m_active); end
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL random_missing: %0d samples never appeared want 0", exp_q.size()); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_square();
      test_saw_back_to_back();
      test_overrun();
      test_amp_change();
      test_drain();
      test_reset_mid();
      test_random_model();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
